selector_velocidad: RTL and testbench

//  Upstream stage of the PWM generator: turns two raw push-buttons (up/down) and
//  an emergency-stop input into the 4-bit duty command 'velocidad' (0..VEL_MAX).

---
 rtl/selector_velocidad_if.sv | 29 ++
 rtl/selector_velocidad.sv | 196 +++++++++++++++++++
 tb/tb_selector_velocidad.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/selector_velocidad_if.sv
`default_nettype none
// ============================================================================
//  Module      : selector_velocidad_if
//  Description : Bundle of the speed-selector signals: raw operator inputs
//                (up/down buttons, emergency stop) and the resulting speed
//                command, target and ramp-active flag.
//                master : drives the buttons/stop, observes the outputs
//                slave  : the selector itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface selector_velocidad_if;
  logic       btn_sube;   // raw up button, active-high, asynchronous
  logic       btn_baja;   // raw down button, active-high, asynchronous
  logic       paro;       // emergency stop level, active-high, asynchronous
  logic [3:0] velocidad;  // duty command to the PWM stage, 0..VEL_MAX
  logic [3:0] objetivo;   // current target speed, 0..VEL_MAX
  logic       en_rampa;   // 1 while the output is ramping

  modport master (
    output btn_sube, btn_baja, paro,
    input  velocidad, objetivo, en_rampa
  );

  modport slave (
    input  btn_sube, btn_baja, paro,
    output velocidad, objetivo, en_rampa
  );
endinterface
`default_nettype wire

// File: rtl/selector_velocidad.sv
`default_nettype none
// ============================================================================
//  Module      : selector_velocidad
//  Description : Upstream stage of the PWM generator. Synchronizes and
//                debounces the up/down buttons, keeps a saturating target
//                speed and ramps the output toward it one step every
//                RAMP_CYCLES. The emergency stop (synchronized only) forces
//                target and output to 0 while asserted.
//  Ports       : clk   - system clock
//                rst_n - asynchronous active-low reset
//                bus   - selector_velocidad_if.slave (buttons, paro,
//                        velocidad, objetivo, en_rampa)
//  Config      : AUTO_REPEAT_EN - when defined, a held button emits an extra
//                press every REPEAT_CYCLES; otherwise one press per press.
//  Revision    : 1.0 - initial release
// ============================================================================
module selector_velocidad #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RAMP_CYCLES     = 5000000,
  parameter int VEL_MAX         = 10,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  selector_velocidad_if.slave  bus
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [3:0] VEL_MAX_V = 4'(VEL_MAX);

  localparam logic [1:0] ESTABLE  = 2'd0;
  localparam logic [1:0] SUBIENDO = 2'd1;
  localparam logic [1:0] BAJANDO  = 2'd2;

  // Two-flop synchronizers: bit 0 = sube, bit 1 = baja, bit 2 = paro
  logic [2:0] sync1_q, sync2_q;
  logic       paro_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.paro, bus.btn_baja, bus.btn_sube};
      sync2_q <= sync1_q;
    end
  end

  assign paro_s = sync2_q[2];

  // Debounced levels and press requests, bit 0 = sube, bit 1 = baja
  logic [1:0] deb_lvl;
  logic [1:0] press_d;
  logic [1:0] pulse_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            deb_q, deb_d;

      // Counter only runs while the synchronized sample disagrees with the
      // accepted level; any agreeing sample restarts the qualification.
      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q[gi] != deb_q) begin
          if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q[gi];
          else                                      cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      end

      assign deb_lvl[gi] = deb_q;

`ifdef AUTO_REPEAT_EN
      localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      logic [REP_W-1:0] rep_q, rep_d;
      logic             rep_hit;
      logic             held_solo;

      // Repeats only while this button alone is held
      assign held_solo = deb_lvl[gi] & ~deb_lvl[1-gi];

      always_comb begin
        rep_hit = 1'b0;
        rep_d   = '0;
        if (held_solo) begin
          if (rep_q == REP_W'(REPEAT_CYCLES - 1)) rep_hit = 1'b1;
          else                                    rep_d   = rep_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
      end

      assign press_d[gi] = (deb_d & ~deb_lvl[gi]) | rep_hit;
`else
      // Keeps REPEAT_CYCLES referenced in builds without auto-repeat
      logic unused_repeat;
      assign unused_repeat = (REPEAT_CYCLES != 0);

      assign press_d[gi] = deb_d & ~deb_lvl[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_q <= '0;
    else        pulse_q <= press_d;
  end

  // Ramp FSM and datapath
  logic [1:0]        state_q, state_d;
  logic [3:0]        vel_q, vel_d, obj_q, obj_d;
  logic [RAMP_W-1:0] cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              paso;

  assign paso = (state_q != ESTABLE) && (cnt_q == RAMP_W'(RAMP_CYCLES - 1));

  // Output value after this cycle; the target comparison guards against
  // stepping past a target that moved since the ramp started.
  always_comb begin
    vel_d = vel_q;
    if (paro_s)
      vel_d = '0;
    else if (paso && state_q == SUBIENDO && vel_q < obj_q)
      vel_d = vel_q + 4'd1;
    else if (paso && state_q == BAJANDO && vel_q > obj_q)
      vel_d = vel_q - 4'd1;
  end

  // Next state: direction follows the post-step output versus the target
  always_comb begin
    state_d = ESTABLE;
    if (!paro_s) begin
      if (vel_d < obj_q)      state_d = SUBIENDO;
      else if (vel_d > obj_q) state_d = BAJANDO;
    end
  end

  // Target, step counter and ramp flag
  always_comb begin
    obj_d = obj_q;
    if (paro_s)
      obj_d = '0;
    else if (pulse_q[0] && !pulse_q[1]) begin
      if (obj_q < VEL_MAX_V) obj_d = obj_q + 4'd1;
    end else if (pulse_q[1] && !pulse_q[0]) begin
      if (obj_q != 4'd0) obj_d = obj_q - 4'd1;
    end

    // Restart on every step, on entry and on direction change
    if (state_d == ESTABLE || state_d != state_q || paso) cnt_d = '0;
    else                                                   cnt_d = cnt_q + 1'b1;

    en_d = (state_d != ESTABLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ESTABLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_q <= '0;
      obj_q <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      vel_q <= vel_d;
      obj_q <= obj_d;
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign bus.velocidad = vel_q;
  assign bus.objetivo  = obj_q;
  assign bus.en_rampa  = en_q;

endmodule
`default_nettype wire

// File: tb/tb_selector_velocidad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_selector_velocidad
//  Description : Self-checking bench for selector_velocidad. Target speed is
//                modelled from the press/saturation rules; the ramp is checked
//                by a monitor for unit steps, RAMP-cycle spacing and the
//                ramp flag. Directed scenarios plus randomized presses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_selector_velocidad;

  localparam int DB   = 4;
  localparam int RAMP = 8;
  localparam int REP  = 32;
  localparam int VMAX = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  selector_velocidad_if bus ();

  selector_velocidad #(
    .DEBOUNCE_CYCLES (DB),
    .RAMP_CYCLES     (RAMP),
    .VEL_MAX         (VMAX),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_obj    = 0;
  bit paro_on  = 1'b0;
  bit mon_en   = 1'b0;
  int peak     = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Clean presses change the target by one with saturation; both at once or
  // shorter than the debounce window change nothing; paro pins it at 0.
  task automatic press(input bit up, input bit dn, input int hold, input int rel);
    bus.btn_sube = up;
    bus.btn_baja = dn;
    repeat (hold) @(negedge clk);
    bus.btn_sube = 1'b0;
    bus.btn_baja = 1'b0;
    repeat (rel) @(negedge clk);
    if (!paro_on && hold >= DB && up != dn) begin
      if (up) m_obj = (m_obj < VMAX) ? m_obj + 1 : VMAX;
      else    m_obj = (m_obj > 0) ? m_obj - 1 : 0;
    end
    check("objetivo", int'(bus.objetivo), m_obj);
  endtask

  task automatic wait_settle(input int budget);
    int n;
    n = 0;
    while (!(bus.velocidad == bus.objetivo && !bus.en_rampa) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("settle_in_budget", int'(n < budget), 1);
  endtask

  // Ramp monitor: unit steps, range, ramp flag versus pending direction and
  // exactly RAMP cycles between steps while the direction is unchanged.
  initial begin : monitor
    int  p_vel, p_obj, seg_start, seg_dir, cur, chg, t, v, o;
    bit  valid;
    valid = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      t++;
      v = int'(bus.velocidad);
      o = int'(bus.objetivo);
      if (!mon_en) begin
        valid = 1'b0;
      end else if (!valid) begin
        p_vel = v; p_obj = o; seg_start = t; seg_dir = 3; valid = 1'b1;
      end else begin
        if (v > peak) peak = v;
        cur = (v < p_obj) ? 1 : (v > p_obj) ? 2 : 0;
        check("en_rampa", int'(bus.en_rampa), int'(cur != 0));
        if (v != p_vel) begin
          check("vel_step", int'(v == p_vel + 1 || v + 1 == p_vel), 1);
          check("vel_max", int'(v <= VMAX), 1);
          chg = (v > p_vel) ? 1 : 2;
          if (seg_dir == chg) check("ramp_interval", t - seg_start, RAMP);
          seg_start = t;
          seg_dir   = cur;
        end else if (cur != seg_dir) begin
          seg_start = t;
          seg_dir   = cur;
        end
        p_vel = v;
        p_obj = o;
      end
    end
  end

  initial begin : stim
    int n, r, h, rev_base;
    bit hit;
    bus.btn_sube = 1'b0;
    bus.btn_baja = 1'b0;
    bus.paro     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_velocidad", int'(bus.velocidad), 0);
    check("rst_objetivo", int'(bus.objetivo), 0);
    check("rst_en_rampa", int'(bus.en_rampa), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Short glitches are rejected, a clean press is accepted
    repeat (5) begin
      bus.btn_sube = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn_sube = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("glitch_objetivo", int'(bus.objetivo), 0);
    press(1'b1, 1'b0, 20, 12);
    wait_settle(100);
    check("one_velocidad", int'(bus.velocidad), 1);
    check("one_en_rampa", int'(bus.en_rampa), 0);

    // Saturation at both ends
    repeat (12) press(1'b1, 1'b0, 6, 6);
    wait_settle(400);
    check("top_velocidad", int'(bus.velocidad), VMAX);
    repeat (12) press(1'b0, 1'b1, 6, 6);
    wait_settle(400);
    check("bottom_velocidad", int'(bus.velocidad), 0);
    check("bottom_objetivo", int'(bus.objetivo), 0);

    // Reversal while ramping up
    peak = 0;
    repeat (6) press(1'b1, 1'b0, 5, 7);
    rev_base = int'(bus.velocidad);
    check("rev_mid_ramp", int'(rev_base < 6), 1);
    repeat (5) press(1'b0, 1'b1, 5, 7);
    wait_settle(300);
    check("rev_velocidad", int'(bus.velocidad), 1);
    check("rev_peak", int'(peak <= 6), 1);

    // Emergency stop mid-ramp
    repeat (6) press(1'b1, 1'b0, 5, 7);
    n = 0;
    while (bus.velocidad < 4'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("paro_ramp_reached", int'(n < 200), 1);
    mon_en  = 1'b0;
    bus.paro = 1'b1;
    paro_on = 1'b1;
    m_obj   = 0;
    repeat (3) @(negedge clk);
    check("paro_velocidad", int'(bus.velocidad), 0);
    check("paro_objetivo", int'(bus.objetivo), 0);
    check("paro_en_rampa", int'(bus.en_rampa), 0);
    press(1'b1, 1'b0, 10, 10);
    press(1'b1, 1'b0, 10, 10);
    bus.paro = 1'b0;
    paro_on  = 1'b0;
    repeat (12) @(negedge clk);
    check("post_paro_objetivo", int'(bus.objetivo), 0);
    check("post_paro_velocidad", int'(bus.velocidad), 0);
    mon_en = 1'b1;
    press(1'b1, 1'b0, 8, 10);
    wait_settle(100);

    // Long hold: auto-repeat adds a press every REP cycles while held
    bus.btn_sube = 1'b1;
    repeat (100) @(negedge clk);
    bus.btn_sube = 1'b0;
    repeat (12) @(negedge clk);
`ifdef AUTO_REPEAT_EN
    m_obj = m_obj + 4;
`else
    m_obj = m_obj + 1;
`endif
    check("hold_objetivo", int'(bus.objetivo), m_obj);
    wait_settle(200);

    // Randomized presses
    repeat (40) begin
      r = int'($urandom_range(0, 9));
      h = int'($urandom_range(5, 20));
      if (r <= 3)      press(1'b1, 1'b0, h, int'($urandom_range(7, 15)));
      else if (r <= 6) press(1'b0, 1'b1, h, int'($urandom_range(7, 15)));
      else if (r == 7) press(1'b1, 1'b1, h, int'($urandom_range(7, 15)));
      else if (r == 8) press(1'b1, 1'b0, int'($urandom_range(1, 2)), 8);
      else             repeat (int'($urandom_range(1, 40))) @(negedge clk);
    end
    wait_settle(500);
    check("rand_velocidad", int'(bus.velocidad), m_obj);

    // Asynchronous reset while ramping
    repeat (10) press(1'b0, 1'b1, 5, 7);
    wait_settle(300);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      bus.btn_sube = ((k % 12) < 5);
      @(negedge clk);
      if (bus.velocidad == 4'd3 && bus.en_rampa) hit = 1'b1;
    end
    check("rst_mid_ramp_reached", int'(hit), 1);
    mon_en = 1'b0;
    bus.btn_sube = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_velocidad", int'(bus.velocidad), 0);
    check("async_rst_objetivo", int'(bus.objetivo), 0);
    check("async_rst_en_rampa", int'(bus.en_rampa), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_objetivo", int'(bus.objetivo), 0);
    check("post_rst_velocidad", int'(bus.velocidad), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
